// File: rtl/pusch_cw_pkg.sv
// Shared sizes, state encoding and weight word layout for the beam code word loader.
package pusch_cw_pkg;

    localparam int ANT      = 32;
    localparam int BEAM     = 16;
    localparam int IW       = 32;
    localparam int CW_WORDS = BEAM * ANT;
    localparam int ANT_W    = $clog2(ANT);
    localparam int BEAM_W   = $clog2(BEAM);
    localparam int HW       = IW / 2;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    // Real half in the upper bits, imaginary half in the lower bits.
    typedef struct packed {
        logic signed [HW-1:0] re;
        logic signed [HW-1:0] im;
    } cw_t;

endpackage

// File: rtl/cw_conj.sv
// Combinational complex conjugate of one weight; the most negative imaginary value saturates.
module cw_conj
    import pusch_cw_pkg::*;
(
    input  cw_t din,
    output cw_t dout
);

    localparam logic [HW-1:0] IM_MIN = {1'b1, {(HW-1){1'b0}}};
    localparam logic [HW-1:0] IM_MAX = {1'b0, {(HW-1){1'b1}}};

    always_comb begin
        dout.re = din.re;
        if (din.im == IM_MIN) begin
            dout.im = IM_MAX;
        end else begin
            dout.im = -din.im;
        end
    end

endmodule

// File: rtl/cw_table_loader.sv
// Double-banked beam-weight table loader: serial writes fill a shadow bank, i_swap copies it to the active bank.
// Optional build macro CW_CONJ_EN conjugates every weight on its way into the shadow bank.
module cw_table_loader
    import pusch_cw_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [IW-1:0]            i_wr_data,
    input  logic                     i_wr_last,
    input  logic                     i_swap,
    output logic [BEAM*ANT*IW-1:0]   o_code_word,
    output logic                     o_table_full,
    output logic                     o_swap_done,
    output logic                     o_err_len,
    output logic                     o_swap_miss
);

    // Handshake: a word transfers on a rising edge where i_wr_valid && o_wr_ready;
    // o_wr_ready never depends on i_wr_valid, and valid while not ready is simply dropped.

    state_t              state_q, state_d;
    logic [ANT_W-1:0]    ant_q, ant_d;
    logic [BEAM_W-1:0]   beam_q, beam_d;
    logic                ready_q;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                miss_q, miss_d;
    logic                accept;
    logic                at_end;
    logic                wr_en;
    logic                do_swap;
    cw_t                 wr_word;

    logic [IW-1:0]           shadow [CW_WORDS];
    logic [BEAM*ANT*IW-1:0]  active_q;

`ifdef CW_CONJ_EN
    cw_conj u_conj (
        .din  (cw_t'(i_wr_data)),
        .dout (wr_word)
    );
`else
    assign wr_word = cw_t'(i_wr_data);
`endif

    assign accept = i_wr_valid && ready_q;
    assign at_end = (ant_q == ANT_W'(ANT - 1)) && (beam_q == BEAM_W'(BEAM - 1));

    always_comb begin
        state_d = state_q;
        ant_d   = ant_q;
        beam_d  = beam_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        miss_d  = 1'b0;
        wr_en   = 1'b0;
        do_swap = 1'b0;
        case (state_q)
            LOAD: begin
                miss_d = i_swap;
                if (accept) begin
                    wr_en = 1'b1;
                    if (i_wr_last && at_end) begin
                        state_d = FULL;
                        ant_d   = '0;
                        beam_d  = '0;
                    end else if (i_wr_last || at_end) begin
                        // Wrong length: restart; the next complete table overwrites every entry.
                        err_d  = 1'b1;
                        ant_d  = '0;
                        beam_d = '0;
                    end else if (ant_q == ANT_W'(ANT - 1)) begin
                        ant_d  = '0;
                        beam_d = beam_q + BEAM_W'(1);
                    end else begin
                        ant_d = ant_q + ANT_W'(1);
                    end
                end
            end
            FULL: begin
                if (i_swap) begin
                    do_swap = 1'b1;
                    done_d  = 1'b1;
                    state_d = LOAD;
                    ant_d   = '0;
                    beam_d  = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= LOAD;
            ant_q   <= '0;
            beam_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ant_q   <= ant_d;
            beam_q  <= beam_d;
            ready_q <= (state_d == LOAD);
            done_q  <= done_d;
            err_q   <= err_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CW_WORDS; i++) begin
                shadow[i] <= '0;
            end
            active_q <= '0;
        end else begin
            if (wr_en) begin
                shadow[{beam_q, ant_q}] <= wr_word;
            end
            if (do_swap) begin
                for (int i = 0; i < CW_WORDS; i++) begin
                    active_q[i*IW +: IW] <= shadow[i];
                end
            end
        end
    end

    assign o_wr_ready   = ready_q;
    assign o_code_word  = active_q;
    assign o_table_full = (state_q == FULL);
    assign o_swap_done  = done_q;
    assign o_err_len    = err_q;
    assign o_swap_miss  = miss_q;

endmodule

// File: tb/tb_cw_table_loader.sv
// Directed bench for cw_table_loader: table loads, length errors, swap misses, FULL back-pressure, mid-load reset.
module tb_cw_table_loader;
    import pusch_cw_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [IW-1:0]           wr_data;
    logic                    wr_last;
    logic                    swap;
    logic [BEAM*ANT*IW-1:0]  code_word;
    logic                    table_full;
    logic                    swap_done;
    logic                    err_len;
    logic                    swap_miss;

    int n_checks = 0;
    int n_fail   = 0;

    cw_table_loader dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_data    (wr_data),
        .i_wr_last    (wr_last),
        .i_swap       (swap),
        .o_code_word  (code_word),
        .o_table_full (table_full),
        .o_swap_done  (swap_done),
        .o_err_len    (err_len),
        .o_swap_miss  (swap_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          pat;
        int          beam;
        int          ant;
        logic [31:0] exp_raw;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] gen(input int pat, input int idx);
        logic [15:0] r;
        r = 16'(511 - idx);
        case (pat)
            0:       gen = 32'(idx);
            1:       gen = 32'h0001_0000 | 32'(idx);
            2:       gen = {16'h5A5A, r};
            default: gen = 32'hDEAD_0000 | 32'(idx);
        endcase
    endfunction

    // What the active bank should hold for a written word.
    function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef CW_CONJ_EN
        logic [15:0] im;
        im = w[15:0];
        if (im == 16'h8000) stored = {w[31:16], 16'h7FFF};
        else                stored = {w[31:16], 16'(-im)};
`else
        stored = w;
`endif
    endfunction

    function automatic logic [31:0] slice(input int b, input int a);
        slice = code_word[(b*ANT+a)*IW +: IW];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_vecs(input int pat);
        foreach (vecs[i]) begin
            if (vecs[i].pat == pat)
                check($sformatf("slice p%0d b%0d a%0d", pat, vecs[i].beam, vecs[i].ant),
                      slice(vecs[i].beam, vecs[i].ant), stored(vecs[i].exp_raw));
        end
    endtask

    // Drives n words back to back from a negedge; last on index last_at; optional swap with the final word.
    task automatic send_words(input int pat, input int n, input int last_at, input bit swap_on_last);
        int stalls;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (!wr_ready) stalls++;
            wr_valid = 1'b1;
            wr_data  = gen(pat, i);
            wr_last  = (i == last_at);
            swap     = swap_on_last && (i == n - 1);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        swap     = 1'b0;
        check($sformatf("ready while loading p%0d stalls", pat), 32'(stalls), 32'd0);
    endtask

    task automatic swap_ok(input string tag);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        check({tag, " swap_done"}, 32'(swap_done), 32'd1);
        check({tag, " ready after swap"}, 32'(wr_ready), 32'd1);
        check({tag, " full after swap"}, 32'(table_full), 32'd0);
        @(negedge clk);
        check({tag, " swap_done one cycle"}, 32'(swap_done), 32'd0);
    endtask

    initial begin
        int err_seen;

        vecs.push_back('{0, 0, 0, 32'h0000_0000});
        vecs.push_back('{0, 3, 5, 32'h0000_0065});
        vecs.push_back('{0, 1, 31, 32'h0000_003F});
        vecs.push_back('{0, 7, 0, 32'h0000_00E0});
        vecs.push_back('{0, 15, 31, 32'h0000_01FF});
        vecs.push_back('{1, 0, 0, 32'h0001_0000});
        vecs.push_back('{1, 3, 3, 32'h0001_0063});
        vecs.push_back('{1, 3, 5, 32'h0001_0065});
        vecs.push_back('{1, 15, 31, 32'h0001_01FF});
        vecs.push_back('{2, 0, 0, 32'h5A5A_01FF});
        vecs.push_back('{2, 3, 5, 32'h5A5A_019A});
        vecs.push_back('{2, 8, 16, 32'h5A5A_00EF});
        vecs.push_back('{2, 15, 31, 32'h5A5A_0000});

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        swap     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ready", 32'(wr_ready), 32'd0);
        check("reset full", 32'(table_full), 32'd0);
        check("reset code_word zero", 32'(code_word == '0), 32'd1);
        check("reset pulses", {29'd0, swap_done, err_len, swap_miss}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", 32'(wr_ready), 32'd1);

        // Table A: data = index.
        send_words(0, 512, 511, 1'b0);
        check("A full", 32'(table_full), 32'd1);
        check("A ready low when full", 32'(wr_ready), 32'd0);
        check("A code_word still zero", 32'(code_word == '0), 32'd1);
        swap_ok("A");
        check_vecs(0);

        // Early last on word 99.
        send_words(3, 100, 99, 1'b0);
        check("early last err_len", 32'(err_len), 32'd1);
        check("early last stays loading", 32'(wr_ready), 32'd1);
        @(negedge clk);
        check("err_len one cycle", 32'(err_len), 32'd0);
        // 512 words without last.
        send_words(3, 512, -1, 1'b0);
        check("missing last err_len", 32'(err_len), 32'd1);
        check("missing last not full", 32'(table_full), 32'd0);
        check("active kept A after errors", slice(3, 5), stored(32'h0000_0065));
        send_words(1, 512, 511, 1'b0);
        check("B full", 32'(table_full), 32'd1);
        swap_ok("B");
        check_vecs(1);

        // Swap while loading, then swap together with the final word.
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        check("idle miss", 32'(swap_miss), 32'd1);
        check("idle miss no done", 32'(swap_done), 32'd0);
        check("idle miss keeps B", slice(3, 5), stored(32'h0001_0065));
        @(negedge clk);
        check("miss one cycle", 32'(swap_miss), 32'd0);
        send_words(2, 512, 511, 1'b1);
        check("final-word swap miss", 32'(swap_miss), 32'd1);
        check("final-word swap full", 32'(table_full), 32'd1);
        check("final-word swap keeps B", slice(15, 31), stored(32'h0001_01FF));

        // Writes attempted while FULL are dropped.
        err_seen = 0;
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            wr_data  = $urandom;
            wr_last  = (i == 19);
            @(negedge clk);
            if (err_len || !table_full || wr_ready) err_seen++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check("FULL ignores writes", 32'(err_seen), 32'd0);
        swap_ok("C");
        check_vecs(2);

        // Reset in the middle of a load.
        send_words(0, 300, -1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset ready", 32'(wr_ready), 32'd0);
        check("mid reset code_word zero", 32'(code_word == '0), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset ready", 32'(wr_ready), 32'd1);
        check("post reset full", 32'(table_full), 32'd0);
        check("post reset code_word zero", 32'(code_word == '0), 32'd1);
        send_words(1, 512, 511, 1'b0);
        swap_ok("reload");
        check_vecs(1);

`ifdef CW_CONJ_EN
        for (int i = 0; i < 512; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i == 0) ? 32'h1234_8000 : (i == 1) ? 32'h0001_0005 : 32'(i);
            wr_last  = (i == 511);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        swap_ok("conj");
        check("conj saturate", slice(0, 0), 32'h1234_7FFF);
        check("conj negate", slice(0, 1), 32'h0001_FFFB);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
